// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues reads to a synchronous instruction memory,
// buffers returned words in a prefetch FIFO and writes the PC on every handoff.
// Optional FETCH_PERF_EN adds a saturating handoff counter (perf_fetch_count).
module fetch_unit #(
  parameter int LENGTH     = 11,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [LENGTH-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [LENGTH-1:0]     redirect_addr,
  input  logic                  halt,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [LENGTH-1:0]     instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [LENGTH-1:0]     new_program_count,
  output logic                  pc_enable
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           perf_fetch_count
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEPTH_C = (OW + 1)'(FIFO_DEPTH);

  logic [LENGTH-1:0]     fa;
  logic                  inf;
  logic [LENGTH-1:0]     inf_addr;
  logic [LENGTH-1:0]     addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] word_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_next;
  logic [OW:0]           committed;
  logic                  pop;
  logic                  push;
  logic                  issue;

  always_comb begin
    instr_valid = (occ != '0);
    instr       = word_q[rd_ptr];
    instr_pc    = addr_q[rd_ptr];
    pop         = instr_valid & instr_ready & ~redirect;
    push        = inf & ~redirect;
    // Slots already owned by buffered words plus the outstanding read, net of this cycle's pop.
    committed   = (OW + 1)'(occ) + (OW + 1)'(inf) - (OW + 1)'(pop);
    issue       = reset & ~halt & ~redirect & (committed < DEPTH_C);
    mem_rd_en   = issue;
    mem_addr    = fa;
    occ_next    = occ + OW'(push) - OW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fa                <= '0;
      inf               <= 1'b0;
      inf_addr          <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      occ               <= '0;
      new_program_count <= '0;
      pc_enable         <= 1'b0;
    end else if (redirect) begin
      fa        <= redirect_addr;
      inf       <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      pc_enable <= 1'b0;
    end else begin
      if (issue) begin
        fa       <= fa + 1'b1;
        inf_addr <= fa;
      end
      inf <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ       <= occ_next;
      pc_enable <= pop;
      if (pop) new_program_count <= instr_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= inf_addr;
      word_q[wr_ptr] <= mem_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_count <= '0;
    end else if (pop && (perf_fetch_count != '1)) begin
      perf_fetch_count <= perf_fetch_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stream/backpressure/redirect/wrap/halt/reset
// sequence; expected handoffs are queued up front and checked by a negedge monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data = 16'hDEAD;
  logic        redirect;
  logic [10:0] redirect_addr;
  logic        halt;
  logic [15:0] instr;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [10:0] new_program_count;
  logic        pc_enable;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_count;
`endif

  fetch_unit #(.LENGTH(11), .DATA_WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_addr          (mem_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_data          (mem_data),
    .redirect          (redirect),
    .redirect_addr     (redirect_addr),
    .halt              (halt),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .new_program_count (new_program_count),
    .pc_enable         (pc_enable)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count  (perf_fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word = addr + 0x100, junk when not read.
  always @(posedge clk) begin
    mem_data <= mem_rd_en ? (16'(mem_addr) + 16'h0100) : 16'hDEAD;
  end

  typedef struct {
    logic [10:0] pc;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [10:0] base, input int unsigned count);
    logic [10:0] pc;
    pc = base;
    for (int unsigned i = 0; i < count; i++) begin
      exp_q.push_back('{pc: pc, word: 16'(pc) + 16'h0100});
      pc = pc + 11'd1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 0);
    check({tag, "_pc_enable"}, 32'(pc_enable), 0);
    check({tag, "_new_program_count"}, 32'(new_program_count), 0);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetch_count"}, 32'(perf_fetch_count), 0);
`endif
  endtask

  // Monitor: checks every handoff against the queue and the following PC write.
  logic        pend = 1'b0;
  logic [10:0] pend_pc = '0;
  logic [10:0] last_npc = '0;
  exp_t        e;

  always @(negedge clk) begin
    if (!reset) begin
      pend     = 1'b0;
      last_npc = '0;
    end else begin
      check("pc_enable", 32'(pc_enable), 32'(pend));
      if (pend) last_npc = pend_pc;
      check("new_program_count", 32'(new_program_count), 32'(last_npc));
      pend = 1'b0;
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_handoff: got pc 0x%0h expected no handoff", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
          check("instr", 32'(instr), 32'(e.word));
          pend    = 1'b1;
          pend_pc = e.pc;
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    instr_ready   = 1'b1;
    halt          = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    push_exp(11'h000, 6);
    push_exp(11'h040, 3);
    push_exp(11'h7FE, 8);
    push_exp(11'h000, 4);

    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    @(posedge clk);
    #1 reset = 1'b1;

    for (int c = 0; c <= 33; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      instr_ready   = !(c >= 2 && c <= 6);
      halt          = (c >= 25 && c <= 27);
      redirect      = (c == 13 || c == 19);
      redirect_addr = (c == 19) ? 11'h7FE : 11'h040;
      if (c == 33) begin
        #2 reset = 1'b0;
        #1 check_reset_state("async_rst");
      end
      @(negedge clk);
      case (c)
        0: begin
          check("c0_mem_rd_en", 32'(mem_rd_en), 1);
          check("c0_mem_addr", 32'(mem_addr), 0);
        end
        1: begin
          check("c1_instr_valid", 32'(instr_valid), 0);
          check("c1_mem_addr", 32'(mem_addr), 1);
        end
        2: begin
          check("c2_instr_valid", 32'(instr_valid), 1);
          check("c2_instr_pc", 32'(instr_pc), 0);
        end
        5: begin
          check("full_mem_rd_en", 32'(mem_rd_en), 0);
          check("full_instr_valid", 32'(instr_valid), 1);
          check("full_head_pc", 32'(instr_pc), 0);
        end
        13: begin
`ifdef FETCH_PERF_EN
          check("perf_six", 32'(perf_fetch_count), 6);
`endif
          check("redir_mem_rd_en", 32'(mem_rd_en), 0);
        end
        14: begin
          check("redir1_instr_valid", 32'(instr_valid), 0);
          check("redir1_mem_rd_en", 32'(mem_rd_en), 1);
          check("redir1_mem_addr", 32'(mem_addr), 32'h40);
        end
        15: check("redir2_instr_valid", 32'(instr_valid), 0);
        16: begin
          check("redir3_instr_valid", 32'(instr_valid), 1);
          check("redir3_instr_pc", 32'(instr_pc), 32'h40);
        end
        20: check("wrap_mem_addr", 32'(mem_addr), 32'h7FE);
        27: begin
          check("halt_instr_valid", 32'(instr_valid), 0);
          check("halt_mem_rd_en", 32'(mem_rd_en), 0);
        end
        28: begin
          check("resume_mem_rd_en", 32'(mem_rd_en), 1);
          check("resume_mem_addr", 32'(mem_addr), 3);
        end
        default: ;
      endcase
    end

    repeat (2) @(negedge clk);
    check_reset_state("rst1");
    @(posedge clk);
    #1 reset = 1'b1;
    instr_ready = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;

    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      instr_ready = (c < 6);
      @(negedge clk);
      case (c)
        0: check("r2c0_mem_addr", 32'(mem_addr), 0);
        1: check("r2c1_instr_valid", 32'(instr_valid), 0);
        2: check("r2c2_instr_pc", 32'(instr_pc), 0);
        default: ;
      endcase
    end

`ifdef FETCH_PERF_EN
    check("perf_after_reset", 32'(perf_fetch_count), 4);
`endif
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
